game_draw_sequencer: RTL
========================

// Module: game_draw_sequencer
// PURPOSE
//  Parametrised successor of the per-frame view controller. It sequences every screen draw (title,
//  background, N object types, M hooks, score, end screens) through one shared draw-command handshake
//  instead of one enable/done pair per drawer. It owns the level counter, the frame-tick divider and the
//  game-phase reset strobes. Sits between the game logic (game_end/next_level) and the draw-engine mux.
// PARAMETERS
//  NUM_OBJ_TYPES  3       object kinds drawn each frame (gold/stone/diamond = 0/1/2), 1..8
//  NUM_HOOKS      2       hooks available in multi-player mode, 1..4
//  NUM_LEVELS     3       levels; clearing level NUM_LEVELS-1 wins, 1..2**LVL_W
//  LVL_W          3       width of level output
//  FRAME_DIV      833334  clk cycles per frame tick (60 Hz @ 50 MHz), >=2
// PORTS
//  clk            in   1              system clock
//  resetn         in   1              async active-low reset
//  go             in   1              start/continue key, level-sensitive, synchronous to clk
//  mode           in   1              0: one hook drawn; 1: NUM_HOOKS hooks drawn
//  reset_done     in   1              game datapath finished clearing
//  game_end       in   1              round over (time out or target met)
//  next_level     in   1              qualifies game_end: 1 = target met
//  obj_max        in   NUM_OBJ_TYPES*5   objects per type, type t at [5t+4:5t], 0 = type absent
//  cmd_valid      out  1              draw command pending
//  cmd_op         out  3              0 TITLE 1 BG 2 OBJ 3 HOOK 4 NUM 5 OVER 6 NEXTLVL 7 WIN
//  cmd_sel        out  3              object type (OBJ) or hook number (HOOK), else 0
//  cmd_idx        out  5              object index within type (OBJ), else 0
//  draw_done      in   1              one-cycle pulse from draw engine, completes current command
//  enable_random  out  1              position generator run
//  timer_enable   out  1              game timer counts
//  time_resetn    out  1              low = clear game timer
//  resetn_rope    out  1              low = park hooks
//  resetn_objects out  1              low = clear caught-object state
//  level          out  LVL_W          current level, 0-based
//  frame_miss     out  8              saturating count of frame ticks missed while not in PLAY
// BEHAVIOUR
//  Reset: state TITLE, cmd_valid=0, cmd_op/sel/idx=0, level=0, frame_miss=0, divider=0, enable_random=0,
//   timer_enable=0, time_resetn=1, resetn_rope=1, resetn_objects=1. All outputs registered except the strobes
//   decoded from state (Moore).
//  Handshake: on entering a draw state, cmd_valid=1 the next cycle with op/sel/idx stable; on draw_done,
//   cmd_valid drops the same edge and the next command has >=1 idle cycle. draw_done while !cmd_valid is ignored.
//  States: TITLE (OP 0, resetn_rope=0) -> WAIT_RST (until reset_done) -> ARM (enable_random=1,
//   time_resetn=0, resetn_rope=0; rising edge of go) -> BG (OP 1) -> OBJ -> HOOK -> NUM (OP 4) -> PLAY.
//  OBJ: iterate t=0..NUM_OBJ_TYPES-1, i=0..obj_max[t]-1, one command each; types with max 0 skipped in 0 cycles
//   of command traffic; if all max are 0, go straight to HOOK.
//  HOOK: sel=0..H-1, H = mode ? NUM_HOOKS : 1; mode sampled on entry to HOOK.
//  timer_enable=1 in BG, OBJ, HOOK, NUM, PLAY. resetn_objects=0 in PLAY (one-frame catch window as before).
//  PLAY: game_end&!next_level -> OVER (OP 5); game_end&next_level -> NEXTLVL (OP 6); else frame tick -> BG.
//   game_end has priority over a simultaneous frame tick.
//  OVER done -> DONE_LOSE (time_resetn=0, resetn_rope=0, resetn_objects=0, level<=0); go rise -> TITLE.
//  NEXTLVL done -> DONE_WIN (same strobes, level kept): if level==NUM_LEVELS-1 -> WIN (OP 7), else go rise ->
//   level<=level+1, -> BG. WIN done -> WIN_WAIT; go rise -> level<=0, -> TITLE.
//  go rise = go & !go_q (go_q registered); held go never retriggers.
//  Divider: free-running 0..FRAME_DIV-1, tick on wrap; any tick while state!=PLAY increments frame_miss,
//   saturating at 255; cleared only by reset.
//  Async reset mid-command: cmd_valid drops immediately; draw engine must abandon the draw.
//  Unknown state encoding -> TITLE next cycle.
// TESTING
//  1 reset; obj_max={2,3,1}, mode=0, reset_done=1, go pulse -> cmd sequence BG, OBJ(0,0..0),(1,0..2),(2,0..1),
//    HOOK 0, NUM; 6 OBJ cmds, each valid until its draw_done pulse.
//  2 mode=1, NUM_HOOKS=2, obj_max=0 -> BG, HOOK 0, HOOK 1, NUM; no OBJ commands.
//  3 in PLAY assert game_end&next_level on the same cycle as frame tick -> OP 6 issued, no BG; level 0 -> 1
//    after go rise.
//  4 clear levels 0,1,2 (NUM_LEVELS=3) -> third NEXTLVL followed by OP 7 WIN; go rise -> level=0, OP 0.
//  5 game_end&!next_level at level 2 -> OVER; go held high through DONE_LOSE -> stays until release+re-press.
//  6 FRAME_DIV=4, hold draw_done low 40 cycles in BG -> frame_miss=10; deassert resetn mid-OBJ -> cmd_valid=0
//    same cycle, all outputs at reset values.

Source files
------------

// File: rtl/game_draw_sequencer.sv
// game_draw_sequencer: sequences every per-frame draw command over one handshake and owns the level,
// frame-tick divider and game-phase reset strobes.
module game_draw_sequencer #(
  parameter int NUM_OBJ_TYPES = 3,
  parameter int NUM_HOOKS     = 2,
  parameter int NUM_LEVELS    = 3,
  parameter int LVL_W         = 3,
  parameter int FRAME_DIV     = 833334
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       go,
  input  logic                       mode,
  input  logic                       reset_done,
  input  logic                       game_end,
  input  logic                       next_level,
  input  logic [NUM_OBJ_TYPES*5-1:0] obj_max,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_op,
  output logic [2:0]                 cmd_sel,
  output logic [4:0]                 cmd_idx,
  input  logic                       draw_done,
  output logic                       enable_random,
  output logic                       timer_enable,
  output logic                       time_resetn,
  output logic                       resetn_rope,
  output logic                       resetn_objects,
  output logic [LVL_W-1:0]           level,
  output logic [7:0]                 frame_miss
);
  localparam int DIV_W = $clog2(FRAME_DIV);
  typedef enum logic [3:0] {
    S_TITLE, S_WAIT_RST, S_ARM, S_BG, S_OBJ, S_HOOK, S_NUM, S_PLAY,
    S_OVER, S_DONE_LOSE, S_NEXTLVL, S_DONE_WIN, S_WIN, S_WIN_WAIT
  } state_t;
  state_t state, nxt;
  logic [DIV_W-1:0] div;
  logic tick, go_q, go_rise, done, draw_st, issue, nz_found, idx_last, last_lvl;
  logic [2:0] obj_t, nz_t, hook_n, hook_last, op_nxt;
  logic [4:0] obj_i;
  logic [3:0] srch;
  logic [4:0] max_arr [8];
  for (genvar g = 0; g < 8; g++) begin : g_max
    if (g < NUM_OBJ_TYPES) begin : g_on
      assign max_arr[g] = obj_max[5*g +: 5];
    end else begin : g_off
      assign max_arr[g] = 5'd0;
    end
  end
  assign tick     = div == DIV_W'(FRAME_DIV - 1);
  assign go_rise  = go & ~go_q;
  assign done     = cmd_valid & draw_done;
  assign draw_st  = state inside {S_TITLE, S_BG, S_OBJ, S_HOOK, S_NUM, S_OVER, S_NEXTLVL, S_WIN};
  assign issue    = draw_st & ~cmd_valid;
  assign last_lvl = level == LVL_W'(NUM_LEVELS - 1);
  assign idx_last = ({1'b0, obj_i} + 6'd1) >= {1'b0, max_arr[obj_t]};
  // From BG the search starts at type 0, from OBJ at the type after the current one
  assign srch     = (state == S_OBJ) ? {1'b0, obj_t} + 4'd1 : 4'd0;
  assign op_nxt   = state == S_TITLE   ? 3'd0 :
                    state == S_BG      ? 3'd1 :
                    state == S_OBJ     ? 3'd2 :
                    state == S_HOOK    ? 3'd3 :
                    state == S_NUM     ? 3'd4 :
                    state == S_OVER    ? 3'd5 :
                    state == S_NEXTLVL ? 3'd6 : 3'd7;
  always_comb begin
    nz_found = 1'b0;
    nz_t = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (4'(k) >= srch && max_arr[k] != 5'd0) begin
        nz_found = 1'b1;
        nz_t = 3'(k);
      end
  end
  always_comb begin
    nxt = state;
    case (state)
      S_TITLE:     nxt = done ? S_WAIT_RST : state;
      S_WAIT_RST:  nxt = reset_done ? S_ARM : state;
      S_ARM:       nxt = go_rise ? S_BG : state;
      S_BG:        nxt = done ? (nz_found ? S_OBJ : S_HOOK) : state;
      S_OBJ:       nxt = (done && idx_last) ? (nz_found ? S_OBJ : S_HOOK) : state;
      S_HOOK:      nxt = (done && hook_n == hook_last) ? S_NUM : state;
      S_NUM:       nxt = done ? S_PLAY : state;
      S_PLAY:      nxt = game_end ? (next_level ? S_NEXTLVL : S_OVER) : tick ? S_BG : state;
      S_OVER:      nxt = done ? S_DONE_LOSE : state;
      S_DONE_LOSE: nxt = go_rise ? S_TITLE : state;
      S_NEXTLVL:   nxt = done ? S_DONE_WIN : state;
      S_DONE_WIN:  nxt = last_lvl ? S_WIN : go_rise ? S_BG : state;
      S_WIN:       nxt = done ? S_WIN_WAIT : state;
      S_WIN_WAIT:  nxt = go_rise ? S_TITLE : state;
      default:     nxt = S_TITLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_TITLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      div        <= '0;
      go_q       <= 1'b0;
      frame_miss <= 8'd0;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      go_q       <= go;
      if (tick && state != S_PLAY && frame_miss != 8'hff) frame_miss <= frame_miss + 8'd1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cmd_valid <= 1'b0;
      cmd_op    <= 3'd0;
      cmd_sel   <= 3'd0;
      cmd_idx   <= 5'd0;
    end else if (issue) begin
      cmd_valid <= 1'b1;
      cmd_op    <= op_nxt;
      cmd_sel   <= state == S_OBJ ? obj_t : state == S_HOOK ? hook_n : 3'd0;
      cmd_idx   <= state == S_OBJ ? obj_i : 5'd0;
    end else if (done) begin
      cmd_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      obj_t     <= 3'd0;
      obj_i     <= 5'd0;
      hook_n    <= 3'd0;
      hook_last <= 3'd0;
      level     <= '0;
    end else begin
      if (done && (state == S_BG || (state == S_OBJ && idx_last))) begin
        obj_t <= nz_t;
        obj_i <= 5'd0;
      end else if (done && state == S_OBJ) begin
        obj_i <= obj_i + 5'd1;
      end
      if (nxt == S_HOOK && state != S_HOOK) begin
        hook_n    <= 3'd0;
        hook_last <= mode ? 3'(NUM_HOOKS - 1) : 3'd0;
      end else if (done && state == S_HOOK) begin
        hook_n <= hook_n + 3'd1;
      end
      if ((state == S_OVER && done) || (state == S_WIN_WAIT && go_rise)) level <= '0;
      else if (state == S_DONE_WIN && nxt == S_BG) level <= level + 1'b1;
    end
  // Strobes follow the next state so they match the state decode one cycle later yet reset inactive
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      enable_random  <= 1'b0;
      timer_enable   <= 1'b0;
      time_resetn    <= 1'b1;
      resetn_rope    <= 1'b1;
      resetn_objects <= 1'b1;
    end else begin
      enable_random  <= nxt == S_ARM;
      timer_enable   <= nxt inside {S_BG, S_OBJ, S_HOOK, S_NUM, S_PLAY};
      time_resetn    <= !(nxt inside {S_ARM, S_DONE_LOSE, S_DONE_WIN});
      resetn_rope    <= !(nxt inside {S_TITLE, S_ARM, S_DONE_LOSE, S_DONE_WIN});
      resetn_objects <= !(nxt inside {S_PLAY, S_DONE_LOSE, S_DONE_WIN});
    end
endmodule
